disp_scan_ctrl: RTL and testbench



---
 rtl/disp_pkg.sv | 29 ++
 rtl/disp_scan_ctrl_bcd_to_seg7.sv | 27 ++
 rtl/disp_scan_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// segment patterns, scan state encoding and brightness step count.
package disp_pkg;

  localparam int STEPS = 16;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // Counter width for a count of n states, never below one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_bcd_to_seg7.sv
// BCD to active-high {g,f,e,d,c,b,a} segment decoder.
// Codes 10..15 render as a blank digit.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Seven-segment scan controller: slot sequencing with blanking, PWM
// brightness, per-digit blink and frame-synchronous double buffering.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS       = 3,
  parameter int BLANK_CNT    = 16,
  parameter int STEP_CNT     = 64,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   i_digits,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blink_mask,
  input  logic                  i_upd_valid,
  output logic                  o_upd_ready,
  input  logic [3:0]            i_bright,
  output logic [DIGITS-1:0]     o_digit_en,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic                  o_frame_start
);

  localparam int CMAX =
    (BLANK_CNT > STEP_CNT) ? BLANK_CNT : STEP_CNT;
  localparam int CW = cw(CMAX);
  localparam int SW = cw(DIGITS);
  localparam int FW = cw(BLINK_FRAMES);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CNT - 1);
  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CNT - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    STEP_MAX   = 4'(STEPS - 1);

  state_t            state_q, state_d;
  logic              started_q, started_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        step_q, step_d;
  logic [3:0]        bright_q, bright_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;

  logic [4*DIGITS-1:0] act_dig_q, act_dig_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   act_mask_q, act_mask_d;
  logic [4*DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_mask_q, pend_mask_d;
  logic                upd_ready_q, upd_ready_d;

  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_start_q, frame_start_d;

  logic              step_start;
  logic              frame_wrap;
  logic [3:0]        dig_mux;
  logic [6:0]        dec_seg;
  logic              lit;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    started_d     = 1'b1;
    frame_start_d = 1'b0;
    frame_wrap    = 1'b0;
    step_start    = 1'b0;
    // First edge after reset enters slot 0 BLANK as a frame boundary
    if (!started_q) begin
      state_d       = ST_BLANK;
      slot_d        = '0;
      cnt_d         = '0;
      step_d        = '0;
      frame_start_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d    = ST_ON;
            cnt_d      = '0;
            step_d     = '0;
            step_start = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ON: begin
          if (cnt_q != STEP_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (step_q != STEP_MAX) begin
              step_d     = step_q + 1'b1;
              step_start = 1'b1;
            end else begin
              state_d = ST_BLANK;
              step_d  = '0;
              if (slot_q == SLOT_LAST) begin
                slot_d        = '0;
                frame_start_d = 1'b1;
                frame_wrap    = 1'b1;
              end else begin
                slot_d = slot_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fcnt_d   = fcnt_q;
    phase_d  = phase_q;
    bright_d = step_start ? i_bright : bright_q;
    if (frame_wrap) begin
      if (fcnt_q == FRAME_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_mask_d  = act_mask_q;
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    pend_mask_d = pend_mask_q;
    upd_ready_d = upd_ready_q;
    // Pending full implies ready low, so promotion and capture never overlap
    if (frame_start_q && !upd_ready_q) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      act_mask_d  = pend_mask_q;
      upd_ready_d = 1'b1;
    end else if (i_upd_valid && upd_ready_q) begin
      pend_dig_d  = i_digits;
      pend_dp_d   = i_dp;
      pend_mask_d = i_blink_mask;
      upd_ready_d = 1'b0;
    end
  end

  assign dig_mux = act_dig_d[{slot_d, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (dig_mux),
    .o_seg (dec_seg)
  );

  always_comb begin
    lit = (state_d == ST_ON)
        && (step_d <= bright_d)
        && !(phase_d && act_mask_d[slot_d]);
    digit_en_d = lit ? (DIGITS'(1) << slot_d) : '0;
    seg_d      = (state_d == ST_ON) ? dec_seg : SEG_BLANK;
    dp_d       = (state_d == ST_ON) && act_dp_d[slot_d];
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      started_q     <= 1'b0;
      slot_q        <= '0;
      cnt_q         <= '0;
      step_q        <= '0;
      bright_q      <= '0;
      fcnt_q        <= '0;
      phase_q       <= 1'b0;
      act_dig_q     <= '1;
      act_dp_q      <= '0;
      act_mask_q    <= '0;
      pend_dig_q    <= '1;
      pend_dp_q     <= '0;
      pend_mask_q   <= '0;
      upd_ready_q   <= 1'b1;
      digit_en_q    <= '0;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      started_q     <= started_d;
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      step_q        <= step_d;
      bright_q      <= bright_d;
      fcnt_q        <= fcnt_d;
      phase_q       <= phase_d;
      act_dig_q     <= act_dig_d;
      act_dp_q      <= act_dp_d;
      act_mask_q    <= act_mask_d;
      pend_dig_q    <= pend_dig_d;
      pend_dp_q     <= pend_dp_d;
      pend_mask_q   <= pend_mask_d;
      upd_ready_q   <= upd_ready_d;
      digit_en_q    <= digit_en_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_digit_en    = digit_en_q;
  assign o_seg         = seg_q;
  assign o_dp          = dp_q;
  assign o_frame_start = frame_start_q;
  assign o_upd_ready   = upd_ready_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: cycle scoreboard against a
// frame-arithmetic model, brightness table and hand-written corner cases.
module tb_disp_scan_ctrl;

  localparam int DIGITS       = 3;
  localparam int BLANK_CNT    = 2;
  localparam int STEP_CNT     = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT_LEN     = BLANK_CNT + 16 * STEP_CNT;
  localparam int FRAME_LEN    = DIGITS * SLOT_LEN;

  logic                i_clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [4*DIGITS-1:0] i_digits = '0;
  logic [DIGITS-1:0]   i_dp = '0;
  logic [DIGITS-1:0]   i_blink_mask = '0;
  logic                i_upd_valid = 1'b0;
  logic [3:0]          i_bright = 4'd15;
  logic                o_upd_ready;
  logic [DIGITS-1:0]   o_digit_en;
  logic [6:0]          o_seg;
  logic                o_dp;
  logic                o_frame_start;

  always #5 i_clk = ~i_clk;

  disp_scan_ctrl #(
    .DIGITS       (DIGITS),
    .BLANK_CNT    (BLANK_CNT),
    .STEP_CNT     (STEP_CNT),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .i_clk         (i_clk),
    .rst_n         (rst_n),
    .i_digits      (i_digits),
    .i_dp          (i_dp),
    .i_blink_mask  (i_blink_mask),
    .i_upd_valid   (i_upd_valid),
    .o_upd_ready   (o_upd_ready),
    .i_bright      (i_bright),
    .o_digit_en    (o_digit_en),
    .o_seg         (o_seg),
    .o_dp          (o_dp),
    .o_frame_start (o_frame_start)
  );

  typedef struct packed {
    logic [DIGITS-1:0] en;
    logic [6:0]        seg;
    logic              dp;
    logic              fs;
    logic              rdy;
  } obs_t;

  typedef struct {
    logic [3:0] bright;
    int         exp_on;
  } bvec_t;

  obs_t sb_q[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   en_cnt = 0;

  int                  t;
  logic [4*DIGITS-1:0] m_act_dig, m_pend_dig;
  logic [DIGITS-1:0]   m_act_dp, m_pend_dp;
  logic [DIGITS-1:0]   m_act_mask, m_pend_mask;
  bit                  m_full;
  logic [3:0]          m_bright;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic obs_t predict();
    obs_t p;
    int pos, slot, frame, s;
    bit ph, on;
    pos   = t % SLOT_LEN;
    slot  = (t % FRAME_LEN) / SLOT_LEN;
    frame = t / FRAME_LEN;
    ph    = ((frame / BLINK_FRAMES) % 2) == 1;
    on    = pos >= BLANK_CNT;
    s     = on ? (pos - BLANK_CNT) / STEP_CNT : 0;
    p.en  = '0;
    if (on && s <= int'(m_bright) && !(ph && m_act_mask[slot]))
      p.en = DIGITS'(1) << slot;
    p.seg = on ? ref_seg(m_act_dig[slot*4 +: 4]) : 7'h00;
    p.dp  = on && m_act_dp[slot];
    p.fs  = (t % FRAME_LEN) == 0;
    p.rdy = !m_full;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_act_dig   = '1;
    m_pend_dig  = '1;
    m_act_dp    = '0;
    m_pend_dp   = '0;
    m_act_mask  = '0;
    m_pend_mask = '0;
    m_full      = 1'b0;
    m_bright    = i_bright;
    t           = 0;
  endtask

  task automatic cyc();
    obs_t e, got;
    int np;
    sb_q.push_back(predict());
    @(negedge i_clk);
    got = {o_digit_en, o_seg, o_dp, o_frame_start, o_upd_ready};
    e   = sb_q.pop_front();
    ncmp++;
    if (got !== e) begin
      nerr++;
      $display("FAIL scan t=%0d: got en=%b seg=%h dp=%b fs=%b rdy=%b want en=%b seg=%h dp=%b fs=%b rdy=%b",
               t, got.en, got.seg, got.dp, got.fs, got.rdy,
               e.en, e.seg, e.dp, e.fs, e.rdy);
    end
    if (o_digit_en != '0) en_cnt++;
    if ((t % FRAME_LEN) == 0 && m_full) begin
      m_act_dig  = m_pend_dig;
      m_act_dp   = m_pend_dp;
      m_act_mask = m_pend_mask;
      m_full     = 1'b0;
    end else if (i_upd_valid && !m_full) begin
      m_pend_dig  = i_digits;
      m_pend_dp   = i_dp;
      m_pend_mask = i_blink_mask;
      m_full      = 1'b1;
    end
    np = (t + 1) % SLOT_LEN;
    if (np >= BLANK_CNT && ((np - BLANK_CNT) % STEP_CNT) == 0)
      m_bright = i_bright;
    @(posedge i_clk);
    #1;
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to(input int m);
    for (int g = 0; g < FRAME_LEN && (t % FRAME_LEN) != m; g++) cyc();
  endtask

  task automatic start();
    model_reset();
    @(negedge i_clk);
    rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    t = 0;
  endtask

  task automatic send(input logic [4*DIGITS-1:0] d,
                      input logic [DIGITS-1:0] dp,
                      input logic [DIGITS-1:0] mk);
    i_digits     = d;
    i_dp         = dp;
    i_blink_mask = mk;
    i_upd_valid  = 1'b1;
    cyc();
    i_upd_valid  = 1'b0;
    i_digits     = 12'h999;
  endtask

  bvec_t bvec[3];

  initial begin
    bvec[0] = '{bright: 4'd0,  exp_on: 1};
    bvec[1] = '{bright: 4'd15, exp_on: 16};
    bvec[2] = '{bright: 4'd7,  exp_on: 8};

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_en",    32'(o_digit_en),    32'h0);
    chk("rst_seg",   32'(o_seg),         32'h0);
    chk("rst_dp",    32'(o_dp),          32'h0);
    chk("rst_fs",    32'(o_frame_start), 32'h0);
    chk("rst_ready", 32'(o_upd_ready),   32'h1);

    start();
    run(FRAME_LEN);

    run_to(10);
    send(12'h321, 3'b010, 3'b000);
    run(2 * FRAME_LEN);

    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < SLOT_LEN && (t % SLOT_LEN) != 0; g++) cyc();
      i_bright = bvec[k].bright;
      en_cnt = 0;
      run(SLOT_LEN);
      chk($sformatf("bright%0d_on", bvec[k].bright),
          32'(en_cnt), 32'(bvec[k].exp_on));
    end
    i_bright = 4'd15;

    run_to(30);
    send(12'h321, 3'b010, 3'b100);
    run(5 * FRAME_LEN);

    run_to(20);
    send(12'h654, 3'b001, 3'b000);
    run_to(0);
    i_digits    = 12'h987;
    i_dp        = 3'b100;
    i_upd_valid = 1'b1;
    cyc();
    cyc();
    i_digits    = 12'h000;
    i_dp        = 3'b111;
    run(3);
    i_upd_valid = 1'b0;
    run(2 * FRAME_LEN);

    run_to(0);
    send(12'h246, 3'b011, 3'b000);
    run(2 * FRAME_LEN);

    run_to(5);
    send(12'h135, 3'b101, 3'b000);
    run_to(SLOT_LEN + BLANK_CNT + 3);
    rst_n = 1'b0;
    #1;
    chk("arst_en",    32'(o_digit_en),    32'h0);
    chk("arst_seg",   32'(o_seg),         32'h0);
    chk("arst_dp",    32'(o_dp),          32'h0);
    chk("arst_fs",    32'(o_frame_start), 32'h0);
    chk("arst_ready", 32'(o_upd_ready),   32'h1);
    repeat (2) @(posedge i_clk);
    start();
    run(2 * FRAME_LEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
